// File: rtl/stream_fifo_rr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO port from N_IN streams; zero-latency data path.
// Grants only when the FIFO has room for a full burst; out_V_V_TREADY passes straight back to the granted producer.
module stream_fifo_rr_arbiter #(
  parameter int N_IN       = 4,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 11,
  parameter int BURST      = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_TDATA,
  input  logic [N_IN-1:0]         in_TVALID,
  output logic [N_IN-1:0]         in_TREADY,
  output logic [WIDTH-1:0]        out_V_V_TDATA,
  output logic                    out_V_V_TVALID,
  input  logic                    out_V_V_TREADY,
  input  logic [CNT_W-1:0]        fifo_count,
  output logic [N_IN-1:0]         grant,
  output logic                    burst_done,
  output logic                    timeout_flag
);

  localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int BEAT_W  = $clog2(BURST + 1);
  localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]     BURST_C   = (CNT_W + 1)'(BURST);
  localparam logic [BEAT_W-1:0]  BEAT_LIM  = BEAT_W'(BURST - 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(N_IN - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     last, pick;
  logic                 pick_vld;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [STALL_W-1:0]   stall_cnt;
  logic [CNT_W:0]       space;
  logic                 has_space;
  logic                 sel_vld;
  logic                 beat;
  logic                 last_beat;
  logic                 stall_out;
  logic                 done_next;
  logic                 to_next;

  // A count above the depth would wrap the subtraction into a huge value, so it is excluded explicitly.
  assign space     = {1'b0, DEPTH_C} - {1'b0, fifo_count};
  assign has_space = (fifo_count <= DEPTH_C) && (space >= BURST_C);

  assign sel_vld   = in_TVALID[last];
  assign beat      = (state == XFER) && sel_vld && out_V_V_TREADY;
  assign last_beat = beat && (beat_cnt == BEAT_LIM);
  assign stall_out = (TIMEOUT != 0) && (state == XFER) && !sel_vld && (stall_cnt == STALL_LIM);

  // Scan downward so the nearest requester after 'last' wins; 'last' itself is considered least.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = last;
    pick_vld = 1'b0;
    for (int k = N_IN; k >= 1; k--) begin
      idx = (int'(last) + k) % N_IN;
      if (in_TVALID[idx]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    done_next      = 1'b0;
    to_next        = 1'b0;
    grant          = '0;
    in_TREADY      = '0;
    out_V_V_TVALID = 1'b0;
    out_V_V_TDATA  = in_TDATA[int'(last)*WIDTH +: WIDTH];
    if (state == IDLE) begin
      if (pick_vld && has_space) state_next = XFER;
    end else begin
      grant[last]     = 1'b1;
      in_TREADY[last] = out_V_V_TREADY;
      out_V_V_TVALID  = sel_vld;
      if (last_beat) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else if (stall_out) begin
        state_next = IDLE;
        to_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      last         <= LAST_RST;
      beat_cnt     <= '0;
      stall_cnt    <= '0;
      burst_done   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_next;
      burst_done   <= done_next;
      timeout_flag <= to_next;
      if (state == IDLE) begin
        beat_cnt  <= '0;
        stall_cnt <= '0;
        if (state_next == XFER) last <= pick;
      end else begin
        if (beat) beat_cnt <= beat_cnt + BEAT_W'(1);
        if (sel_vld) stall_cnt <= '0;
        else if (TIMEOUT != 0) stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

endmodule
